mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//   Data-side bus bridge between the core's memory stage and its memory-mapped slaves (data RAM, GPIO).
//   Decodes the address, drives the selected slave's WE/A/WD, and waits out the slave's registered read.
//   Returns lane-extracted, sign- or zero-extended load data and stalls the pipeline until the access completes.
//   Slaves use registered 1-cycle read data: RD reflects the A presented in the previous cycle.
// PARAMETERS
//   GPIO_ADDR     32'h80000000  word address of GPIO region (4 bytes, GPIO_ADDR..GPIO_ADDR+3)
//   RAM_BASE      32'h00000000  base of data RAM region
//   RAM_AW        10            RAM region size = 2**RAM_AW bytes
// PORTS
//   CLK           in   1   system clock, rising edge
//   reset_n       in   1   asynchronous, active-low reset
//   req_valid     in   1   memory stage has a load/store; held stable while stall=1
//   req_we        in   1   1=store, 0=load
//   req_size      in   2   00 byte, 01 half, 10 word, 11 illegal (error)
//   req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data, right-justified
//   stall         out  1   freeze pipeline
//   rsp_valid     out  1   1-cycle pulse: access complete
//   rsp_rdata     out  32  extended load data (0 for stores/errors)
//   rsp_err       out  1   misaligned/unmapped/illegal size, valid with rsp_valid
//   ram_we, ram_be[3:0], ram_addr[31:0], ram_wd[31:0]  out  RAM strobe, byte enables, word-aligned addr, lane data
//   ram_rd        in   32  RAM registered read data
//   gpio_we, gpio_a[31:0], gpio_wd[31:0]  out  GPIO strobe, word-aligned addr, lane data
//   gpio_rd       in   32  GPIO registered read data
// BEHAVIOUR
//   Reset (reset_n=0): state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; ram_we=gpio_we=0, ram_be=0;
//     ram_addr=gpio_a=0, wd=0; stall forced 0. Reset mid-access aborts it; no strobe is issued after reset.
//   FSM: IDLE, ISSUE, WAIT, RESP.
//     IDLE: req_valid=1 -> latch request; stall=1 (combinational). Legal+mapped -> ISSUE, else -> RESP(err).
//     ISSUE (1 cycle): drive selected slave A (addr & ~3), lane-shifted WD; WE=1 only for stores, this cycle only.
//       Store -> RESP. Load -> WAIT. stall=1.
//     WAIT (1 cycle): capture selected slave RD, extract lane, extend into rsp_rdata; slave A still held. stall=1.
//     RESP (1 cycle): rsp_valid=1, stall=0, outputs from registers; always -> IDLE (no re-accept of held req).
//   Latency: load 4 cycles IDLE..RESP; store 3; error 2. Back-to-back accesses: each new request takes at least 1 IDLE cycle.
//   Unselected slave outputs: WE=0, A=0, WD=0. Non-ISSUE/WAIT cycles: all slave A=0.
//   Decode: GPIO if addr[31:2]==GPIO_ADDR[31:2]; RAM if addr in [RAM_BASE, RAM_BASE+2**RAM_AW). Else unmapped.
//   Alignment: half needs addr[0]=0; word needs addr[1:0]=0; violation -> err.
//   Store lanes: byte -> wdata[7:0] in lane addr[1:0], be=0001<<lane. Half -> wdata[15:0] in lane addr[1]*2, be=0011<<lane.
//     Word: be=1111. GPIO ignores be (GPIO latches WD[0] only).
//   Load extract: byte = rd[8*lane+:8]; half = rd[16*addr[1]+:16]; extend per req_unsigned; word unchanged.
//   Error response: rsp_err=1, rsp_rdata=0, no slave strobe in any cycle.
//   rsp_valid, rsp_err and rsp_rdata are 0 outside RESP.
// TESTING
//   sw 0x1 @0x80000000 -> gpio_we=1 exactly 1 cycle (ISSUE), gpio_wd=1; rsp_valid in cycle 3; then lw @0x80000000 -> rsp_rdata=0x1.
//   RAM word 0x8000FF80 @0x10; lb @0x10 -> 0xFFFFFF80; lbu -> 0x00000080; lh @0x12 -> 0xFFFF8000; lw -> 0x8000FF80.
//   sh 0xBEEF @0x06 -> ram_be=1100, ram_wd=0xBEEF0000, ram_addr=0x04; lw @0x04 -> upper half 0xBEEF.
//   lw @0x02 (misaligned), lw @0x40000000 (unmapped) -> no strobes, 2-cycle rsp_err=1, rsp_rdata=0.
//   reset_n low during WAIT of load -> rsp_valid never pulses; after release state IDLE, stall=0 with req_valid=0.
//   Back-to-back sw/lw to GPIO with req_valid held -> exactly one gpio_we per store, no duplicate access after RESP.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Data-side bridge from memory stage to RAM/GPIO slaves; load 4 cycles, store 3, error 2 (IDLE..RESP).
// Backpressure: stall holds the pipeline from request acceptance until the single-cycle RESP pulse.
module mem_bus_bridge #(
    parameter logic [31:0] GPIO_ADDR = 32'h8000_0000,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int          RAM_AW    = 10
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd,
    output logic        gpio_we,
    output logic [31:0] gpio_a,
    output logic [31:0] gpio_wd,
    input  logic [31:0] gpio_rd
);

    localparam logic [32:0] RAM_BYTES = 33'(1) << RAM_AW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_uns;
    logic        r_gpio;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;

    logic [1:0]  w_lane;
    logic        w_is_gpio;
    logic [31:0] w_ram_off;
    logic        w_is_ram;
    logic        w_misalign;
    logic        w_legal;
    logic [31:0] w_wd;
    logic [3:0]  w_be;
    logic [31:0] w_word_addr;
    logic [31:0] w_rd_sel;
    logic [31:0] w_ld_data;

    assign w_lane      = req_addr[1:0];
    assign w_word_addr = {req_addr[31:2], 2'b00};
    assign w_is_gpio   = (req_addr[31:2] == GPIO_ADDR[31:2]);
    assign w_ram_off   = req_addr - RAM_BASE;
    assign w_is_ram    = ({1'b0, w_ram_off} < RAM_BYTES);
    assign w_misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_legal     = (req_size != 2'b11) && !w_misalign && (w_is_gpio || w_is_ram);

    // Store data is placed in its byte lane with unused lanes zeroed.
    always_comb begin
        w_wd = 32'h0;
        w_be = 4'h0;
        case (req_size)
            2'b00: begin
                w_wd = 32'(req_wdata[7:0]) << {w_lane, 3'b000};
                w_be = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_wd = 32'(req_wdata[15:0]) << {w_lane[1], 4'b0000};
                w_be = 4'b0011 << w_lane;
            end
            2'b10: begin
                w_wd = req_wdata;
                w_be = 4'b1111;
            end
            default: begin
                w_wd = 32'h0;
                w_be = 4'h0;
            end
        endcase
    end

    assign w_rd_sel = r_gpio ? gpio_rd : ram_rd;

    always_comb begin
        logic [7:0]  v_b;
        logic [15:0] v_h;
        v_b       = w_rd_sel[{r_lane, 3'b000} +: 8];
        v_h       = w_rd_sel[{r_lane[1], 4'b0000} +: 16];
        w_ld_data = w_rd_sel;
        case (r_size)
            2'b00:   w_ld_data = r_uns ? {24'h0, v_b} : {{24{v_b[7]}}, v_b};
            2'b01:   w_ld_data = r_uns ? {16'h0, v_h} : {{16{v_h[15]}}, v_h};
            default: w_ld_data = w_rd_sel;
        endcase
    end

    // Reset gates stall so a held req_valid cannot freeze the pipe during reset.
    assign stall = reset_n && (((r_state == S_IDLE) && req_valid) ||
                               (r_state == S_ISSUE) || (r_state == S_WAIT));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_gpio    <= 1'b0;
            r_size    <= 2'b00;
            r_lane    <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= 4'h0;
            ram_addr  <= 32'h0;
            ram_wd    <= 32'h0;
            gpio_we   <= 1'b0;
            gpio_a    <= 32'h0;
            gpio_wd   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    if (req_valid) begin
                        r_we   <= req_we;
                        r_uns  <= req_unsigned;
                        r_size <= req_size;
                        r_lane <= w_lane;
                        r_gpio <= w_is_gpio;
                        if (w_legal) begin
                            r_state <= S_ISSUE;
                            if (w_is_gpio) begin
                                gpio_we <= req_we;
                                gpio_a  <= w_word_addr;
                                gpio_wd <= w_wd;
                            end else begin
                                ram_we   <= req_we;
                                ram_be   <= req_we ? w_be : 4'h0;
                                ram_addr <= w_word_addr;
                                ram_wd   <= w_wd;
                            end
                        end else begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    ram_we  <= 1'b0;
                    ram_be  <= 4'h0;
                    gpio_we <= 1'b0;
                    if (r_we) begin
                        ram_addr  <= 32'h0;
                        ram_wd    <= 32'h0;
                        gpio_a    <= 32'h0;
                        gpio_wd   <= 32'h0;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rsp_rdata <= w_ld_data;
                    rsp_valid <= 1'b1;
                    ram_addr  <= 32'h0;
                    ram_wd    <= 32'h0;
                    gpio_a    <= 32'h0;
                    gpio_wd   <= 32'h0;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with behavioural RAM/GPIO slaves and a response scoreboard.
module tb_mem_bus_bridge;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_we, gpio_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wd, ram_rd, gpio_a, gpio_wd, gpio_rd;

    mem_bus_bridge dut (
        .CLK(CLK), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd),
        .gpio_we(gpio_we), .gpio_a(gpio_a), .gpio_wd(gpio_wd), .gpio_rd(gpio_rd)
    );

    always #5 CLK = ~CLK;

    // Slave models: registered read of the address presented in the previous cycle.
    logic [31:0] ram_mem [0:255];
    logic        gpio_q = 1'b0;
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
        ram_rd  = 32'h0;
        gpio_rd = 32'h0;
    end
    always @(posedge CLK) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) ram_mem[ram_addr[9:2]][8*i +: 8] <= ram_wd[8*i +: 8];
        ram_rd <= ram_mem[ram_addr[9:2]];
        if (gpio_we) gpio_q <= gpio_wd[0];
        gpio_rd <= {31'h0, gpio_q};
    end

    int          n_vec = 0, n_err = 0;
    int          n_gpio_we = 0, n_ram_we = 0, n_rsp = 0, n_leak = 0;
    logic [31:0] last_gpio_wd, last_gpio_a, last_ram_wd, last_ram_addr;
    logic [3:0]  last_ram_be;
    logic [32:0] exp_q [$];

    always @(negedge CLK) begin
        if (gpio_we) begin n_gpio_we++; last_gpio_wd = gpio_wd; last_gpio_a = gpio_a; end
        if (ram_we) begin n_ram_we++; last_ram_wd = ram_wd; last_ram_addr = ram_addr; last_ram_be = ram_be; end
        if (rsp_valid) n_rsp++;
        if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) n_leak++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        int          lat;
        int          stall_lo;
        logic [32:0] e;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        exp_q.push_back({exp_e, exp_d});
        lat = 0; stall_lo = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge CLK);
            if (rsp_valid) lat = c;
            else if (!stall) stall_lo++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall gaps"}, 32'(stall_lo), 32'h0);
        check({tag, " stall at resp"}, {31'h0, stall}, 32'h0);
        e = exp_q.pop_front();
        check({tag, " rdata"}, rsp_rdata, e[31:0]);
        check({tag, " err"}, {31'h0, rsp_err}, {31'h0, e[32]});
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    int g0, r0, s0;

    initial begin
        reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h8000_0000; req_wdata = 32'h1;
        repeat (2) @(negedge CLK);
        check("rst stall", {31'h0, stall}, 32'h0);
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst rdata", rsp_rdata, 32'h0);
        check("rst err", {31'h0, rsp_err}, 32'h0);
        check("rst strobes", {30'h0, ram_we, gpio_we}, 32'h0);
        check("rst be", {28'h0, ram_be}, 32'h0);
        check("rst addrs", ram_addr | gpio_a | ram_wd | gpio_wd, 32'h0);
        req_valid = 1'b0;
        reset_n = 1'b1;

        // GPIO store then load
        g0 = n_gpio_we;
        access("sw gpio", 1, 2'b10, 0, 32'h8000_0000, 32'h1, 32'h0, 0, 3); idle();
        check("sw gpio we count", 32'(n_gpio_we - g0), 32'h1);
        check("sw gpio wd", last_gpio_wd, 32'h1);
        check("sw gpio a", last_gpio_a, 32'h8000_0000);
        access("lw gpio", 0, 2'b10, 0, 32'h8000_0000, 32'h0, 32'h1, 0, 4); idle();

        // RAM word and sub-word loads
        access("sw ram", 1, 2'b10, 0, 32'h10, 32'h8000_FF80, 32'h0, 0, 3); idle();
        check("sw ram be", {28'h0, last_ram_be}, 32'hF);
        check("sw ram wd", last_ram_wd, 32'h8000_FF80);
        access("lb 10", 0, 2'b00, 0, 32'h10, 0, 32'hFFFF_FF80, 0, 4); idle();
        access("lbu 10", 0, 2'b00, 1, 32'h10, 0, 32'h0000_0080, 0, 4); idle();
        access("lh 12", 0, 2'b01, 0, 32'h12, 0, 32'hFFFF_8000, 0, 4); idle();
        access("lhu 12", 0, 2'b01, 1, 32'h12, 0, 32'h0000_8000, 0, 4); idle();
        access("lb 11", 0, 2'b00, 0, 32'h11, 0, 32'hFFFF_FFFF, 0, 4); idle();
        access("lw 10", 0, 2'b10, 0, 32'h10, 0, 32'h8000_FF80, 0, 4); idle();

        // Half and byte stores into upper lanes
        access("sh 06", 1, 2'b01, 0, 32'h06, 32'h1234_BEEF, 32'h0, 0, 3); idle();
        check("sh be", {28'h0, last_ram_be}, 32'hC);
        check("sh wd", last_ram_wd, 32'hBEEF_0000);
        check("sh addr", last_ram_addr, 32'h4);
        access("lw 04", 0, 2'b10, 0, 32'h04, 0, 32'hBEEF_0000, 0, 4); idle();
        access("sb 3ff", 1, 2'b00, 0, 32'h3FF, 32'hFFFF_FFA5, 32'h0, 0, 3); idle();
        check("sb be", {28'h0, last_ram_be}, 32'h8);
        check("sb wd", last_ram_wd, 32'hA500_0000);
        check("sb addr", last_ram_addr, 32'h3FC);
        access("lbu 3ff", 0, 2'b00, 1, 32'h3FF, 0, 32'h0000_00A5, 0, 4); idle();
        access("lb 3ff", 0, 2'b00, 0, 32'h3FF, 0, 32'hFFFF_FFA5, 0, 4); idle();

        // Error cases: no strobes, 2-cycle response
        g0 = n_gpio_we; r0 = n_ram_we;
        access("lw misalign", 0, 2'b10, 0, 32'h02, 0, 32'h0, 1, 2); idle();
        access("lw unmapped", 0, 2'b10, 0, 32'h4000_0000, 0, 32'h0, 1, 2); idle();
        access("lw ram end", 0, 2'b10, 0, 32'h400, 0, 32'h0, 1, 2); idle();
        access("sh odd", 1, 2'b01, 0, 32'h05, 32'hFFFF, 32'h0, 1, 2); idle();
        access("size 11", 0, 2'b11, 0, 32'h10, 0, 32'h0, 1, 2); idle();
        access("gpio+4", 1, 2'b10, 0, 32'h8000_0004, 32'h1, 32'h0, 1, 2); idle();
        check("err no strobes", 32'(n_gpio_we - g0 + n_ram_we - r0), 32'h0);

        // Reset during WAIT of a load
        s0 = n_rsp;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(negedge CLK); @(negedge CLK);
        @(posedge CLK); #1;
        reset_n = 1'b0;
        @(negedge CLK);
        check("mid rst stall", {31'h0, stall}, 32'h0);
        check("mid rst ram_addr", ram_addr, 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("post rst stall", {31'h0, stall}, 32'h0);
        check("post rst no rsp", 32'(n_rsp - s0), 32'h0);
        access("lw after rst", 0, 2'b10, 0, 32'h10, 0, 32'h8000_FF80, 0, 4); idle();

        // Back-to-back GPIO with req_valid held throughout
        g0 = n_gpio_we; s0 = n_rsp;
        access("b2b sw", 1, 2'b10, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 3);
        access("b2b lw", 0, 2'b10, 0, 32'h8000_0000, 0, 32'h0, 0, 4);
        access("b2b sw2", 1, 2'b00, 0, 32'h8000_0000, 32'h1, 32'h0, 0, 3);
        idle();
        repeat (4) @(negedge CLK);
        check("b2b gpio we count", 32'(n_gpio_we - g0), 32'h2);
        check("b2b rsp count", 32'(n_rsp - s0), 32'h3);
        access("b2b lw final", 0, 2'b10, 0, 32'h8000_0000, 0, 32'h1, 0, 4); idle();

        repeat (2) @(negedge CLK);
        check("rsp fields outside RESP", 32'(n_leak), 32'h0);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
